// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Round-robin traffic-light sequencer over NUM_DIR approaches. Each approach
// gets GREEN -> YELLOW -> ALL_RED before the next approach is served. An
// optional pedestrian WALK phase is inserted after the all-red clearance when
// a request is pending at yellow exit. A flashing-yellow override preempts
// every other state.
//
// Build option:
//   TLC_PED_EN  defined   -> pending flag, WALK state, ped_ack and walk exist.
//               undefined -> ped_req ignored, ped_ack/walk tied to 0.
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   synchronous active-low reset
//   enable      in   1 = dwell counter runs, 0 = freeze state/counter/blink
//   flash       in   level, 1 = flashing-yellow override
//   ped_req     in   pedestrian request, sampled every clock
//   ped_ack     out  one-clock pulse on WALK entry
//   walk        out  1 while in WALK
//   light       out  per approach d: light[3d+2:3d] = {red, green, yellow}
//   active_dir  out  approach currently served
//   phase       out  0 ALL_RED, 1 GREEN, 2 YELLOW, 3 WALK, 4 FLASH
//
// All outputs come straight from flops and change on the same edge as state.
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int NUM_DIR    = 2,
  parameter int CNT_W      = 16,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6,
  parameter int FLASH_CYC  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       flash,
  input  logic                       ped_req,
  output logic                       ped_ack,
  output logic                       walk,
  output logic [3*NUM_DIR-1:0]       light,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [2:0]                 phase
);

  localparam int DIR_W = $clog2(NUM_DIR);

  // Encodings double as the phase output.
  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    WALK    = 3'd3,
    FLASH   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_CYC - 1);

  state_e               state_q, state_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 blink_q, blink_d;
  // Set at yellow exit so the following ALL_RED exit moves to the next
  // approach; clear after reset/flash so service restarts at approach 0.
  logic                 adv_q, adv_d;
  logic [3*NUM_DIR-1:0] light_q, light_d;

`ifdef TLC_PED_EN
  localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_CYC - 1);

  logic pend_q, pend_d;     // request waiting for service
  logic wnext_q, wnext_d;   // this ALL_RED leads into WALK
  logic ack_q, ack_d;
  logic walk_q, walk_d;
`else
  logic unused_ped;
  assign unused_ped = ped_req ^ WALK_CYC[0];
`endif

  // NOTE: every variable is given a default at the top of the block so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    adv_d   = adv_q;
`ifdef TLC_PED_EN
    pend_d  = pend_q;
    wnext_d = wnext_q;
    if (ped_req && state_q != WALK) pend_d = 1'b1;
`endif

    if (flash) begin
      // Override wins regardless of enable; any WALK plan is dropped.
      state_d = FLASH;
      adv_d   = 1'b0;
`ifdef TLC_PED_EN
      pend_d  = 1'b0;
      wnext_d = 1'b0;
`endif
      if (state_q != FLASH) begin
        cnt_d   = FLASH_LD;
        blink_d = 1'b1;
      end else if (enable) begin
        if (cnt_q == '0) begin
          cnt_d   = FLASH_LD;
          blink_d = ~blink_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end else if (state_q == FLASH) begin
      state_d = ALL_RED;
      dir_d   = '0;
      cnt_d   = ALLRED_LD;
      adv_d   = 1'b0;
    end else if (enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unique case (state_q)
          GREEN: begin
            state_d = YELLOW;
            cnt_d   = YELLOW_LD;
          end
          YELLOW: begin
            state_d = ALL_RED;
            cnt_d   = ALLRED_LD;
            adv_d   = 1'b1;
`ifdef TLC_PED_EN
            // A request arriving on this very edge still counts.
            wnext_d = pend_q | ped_req;
`endif
          end
          ALL_RED: begin
`ifdef TLC_PED_EN
            if (wnext_q) begin
              state_d = WALK;
              cnt_d   = WALK_LD;
              wnext_d = 1'b0;
              pend_d  = 1'b0;
            end else
`endif
            begin
              state_d = GREEN;
              cnt_d   = GREEN_LD;
              adv_d   = 1'b0;
              if (adv_q)
                dir_d = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
            end
          end
`ifdef TLC_PED_EN
          WALK: begin
            state_d = ALL_RED;
            cnt_d   = ALLRED_LD;
          end
`endif
          default: begin
            state_d = ALL_RED;
            cnt_d   = ALLRED_LD;
          end
        endcase
      end
    end

    // Lamp drive is computed from the next state so it registers with it.
    light_d = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      unique case (state_d)
        GREEN:   light_d[3*d +: 3] = (DIR_W'(d) == dir_d) ? 3'b010 : 3'b100;
        YELLOW:  light_d[3*d +: 3] = (DIR_W'(d) == dir_d) ? 3'b001 : 3'b100;
        FLASH:   light_d[3*d +: 3] = {2'b00, blink_d};
        default: light_d[3*d +: 3] = 3'b100;
      endcase
    end

`ifdef TLC_PED_EN
    ack_d  = (state_d == WALK) && (state_q != WALK);
    walk_d = (state_d == WALK);
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ALL_RED;
      dir_q   <= '0;
      cnt_q   <= ALLRED_LD;
      blink_q <= 1'b1;
      adv_q   <= 1'b0;
      light_q <= {NUM_DIR{3'b100}};
`ifdef TLC_PED_EN
      pend_q  <= 1'b0;
      wnext_q <= 1'b0;
      ack_q   <= 1'b0;
      walk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      adv_q   <= adv_d;
      light_q <= light_d;
`ifdef TLC_PED_EN
      pend_q  <= pend_d;
      wnext_q <= wnext_d;
      ack_q   <= ack_d;
      walk_q  <= walk_d;
`endif
    end
  end

  assign light      = light_q;
  assign active_dir = dir_q;
  assign phase      = state_q;
`ifdef TLC_PED_EN
  assign ped_ack    = ack_q;
  assign walk       = walk_q;
`else
  assign ped_ack    = 1'b0;
  assign walk       = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Directed bench for traffic_light_ctrl with NUM_DIR=2, GREEN=4, YELLOW=2,
// ALLRED=1, WALK=3, FLASH=2. "Cycle k" is the clock period ending at the k-th
// rising edge after reset release; outputs are sampled on the falling edge
// inside that period. Pedestrian scenarios are selected by TLC_PED_EN.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       flash = 1'b0;
  logic       ped_req = 1'b0;
  logic       ped_ack;
  logic       walk;
  logic [5:0] light;
  logic [0:0] active_dir;
  logic [2:0] phase;

  int nvec = 0;
  int nerr = 0;

  traffic_light_ctrl #(
    .NUM_DIR(2), .CNT_W(16), .GREEN_CYC(4), .YELLOW_CYC(2),
    .ALLRED_CYC(1), .WALK_CYC(3), .FLASH_CYC(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .flash(flash),
    .ped_req(ped_req), .ped_ack(ped_ack), .walk(walk), .light(light),
    .active_dir(active_dir), .phase(phase)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves the bench on the falling edge of cycle 0.
  task automatic restart();
    @(negedge clock);
    reset_n = 1'b0;
    flash   = 1'b0;
    ped_req = 1'b0;
    enable  = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] ep,
                            input logic [5:0] el, input logic ed,
                            input logic ew, input logic ea);
    nvec++;
    if (phase !== ep || light !== el || active_dir !== ed ||
        walk !== ew || ped_ack !== ea) begin
      nerr++;
      $display("FAIL %s: got phase=%0d light=%b dir=%0d walk=%b ack=%b, need phase=%0d light=%b dir=%0d walk=%b ack=%b",
               name, phase, light, active_dir, walk, ped_ack, ep, el, ed, ew, ea);
    end
  endtask

  task automatic test_reset();
    restart();
    expect_out("reset_state", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
  endtask

  // Full rotation 0..15; optionally pulses ped_req, which must not matter
  // when the pedestrian feature is not built.
  task automatic test_rotation(input bit pulse_ped);
    logic [5:0] el [0:15];
    logic [2:0] ep [0:15];
    logic       ed [0:15];
    el = '{6'b100100, 6'b100010, 6'b100010, 6'b100010, 6'b100010, 6'b100001,
           6'b100001, 6'b100100, 6'b010100, 6'b010100, 6'b010100, 6'b010100,
           6'b001100, 6'b001100, 6'b100100, 6'b100010};
    ep = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0,
           3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0, 3'd1};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    restart();
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step(1);
      ped_req = pulse_ped && (c == 2 || c == 6 || c == 9);
      expect_out($sformatf("rotation%0d_c%0d", pulse_ped, c), ep[c], el[c], ed[c], 1'b0, 1'b0);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_enable();
    restart();
    step(2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef TLC_PED_EN
      ped_req = (i == 1);
`endif
      step(1);
      expect_out($sformatf("freeze_%0d", i), 3'd1, 6'b100010, 1'b0, 1'b0, 1'b0);
    end
    ped_req = 1'b0;
    enable = 1'b1;
    step(1);
    expect_out("resume_green_a", 3'd1, 6'b100010, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("resume_green_b", 3'd1, 6'b100010, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("resume_yellow", 3'd2, 6'b100001, 1'b0, 1'b0, 1'b0);
    step(2);
    expect_out("resume_allred", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    step(1);
`ifdef TLC_PED_EN
    expect_out("frozen_req_walk", 3'd3, 6'b100100, 1'b0, 1'b1, 1'b1);
`else
    expect_out("resume_green1", 3'd1, 6'b010100, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_flash();
    restart();
    step(8);
    expect_out("pre_flash_green1", 3'd1, 6'b010100, 1'b1, 1'b0, 1'b0);
    flash = 1'b1;
    step(1);
    expect_out("flash_on", 3'd4, 6'b001001, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_out("flash_hold", 3'd4, 6'b001001, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_out("flash_off_a", 3'd4, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_out("flash_off_b", 3'd4, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_out("flash_on_again", 3'd4, 6'b001001, 1'b1, 1'b0, 1'b0);
    flash = 1'b0;
    step(1);
    expect_out("flash_exit_allred", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    step(1);
    nvec++;
    if (phase !== 3'd1) begin
      nerr++;
      $display("FAIL flash_exit_dwell: got phase=%0d, need 1", phase);
    end
  endtask

  task automatic test_reset_mid();
    restart();
`ifdef TLC_PED_EN
    step(3);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(1);
`else
    step(5);
`endif
    expect_out("pre_reset_yellow", 3'd2, 6'b100001, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(1);
    expect_out("mid_reset", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(7);
    expect_out("post_reset_allred", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("post_reset_no_walk", 3'd1, 6'b010100, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef TLC_PED_EN
  task automatic test_ped();
    restart();
    step(2);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(4);
    expect_out("ped_allred_c7", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("ped_walk_c8", 3'd3, 6'b100100, 1'b0, 1'b1, 1'b1);
    step(1);
    ped_req = 1'b1;
    expect_out("ped_walk_c9", 3'd3, 6'b100100, 1'b0, 1'b1, 1'b0);
    step(1);
    ped_req = 1'b0;
    expect_out("ped_walk_c10", 3'd3, 6'b100100, 1'b0, 1'b1, 1'b0);
    step(1);
    expect_out("ped_allred_c11", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("ped_green1_c12", 3'd1, 6'b010100, 1'b1, 1'b0, 1'b0);
    step(6);
    expect_out("ped_allred_c18", 3'd0, 6'b100100, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_out("ped_no_extra_c19", 3'd1, 6'b100010, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ped_at_yellow_exit();
    restart();
    step(6);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    expect_out("late_req_allred", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("late_req_walk", 3'd3, 6'b100100, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_flash_abort_walk();
    restart();
    step(2);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    step(6);
    expect_out("abort_in_walk", 3'd3, 6'b100100, 1'b0, 1'b1, 1'b0);
    flash = 1'b1;
    step(1);
    expect_out("abort_flash", 3'd4, 6'b001001, 1'b0, 1'b0, 1'b0);
    flash = 1'b0;
    step(1);
    expect_out("abort_allred", 3'd0, 6'b100100, 1'b0, 1'b0, 1'b0);
    step(1);
    nvec++;
    if (phase !== 3'd1 || walk !== 1'b0) begin
      nerr++;
      $display("FAIL abort_no_walk: got phase=%0d walk=%b, need phase=1 walk=0", phase, walk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation(1'b0);
    test_enable();
    test_flash();
    test_reset_mid();
`ifdef TLC_PED_EN
    test_ped();
    test_ped_at_yellow_exit();
    test_flash_abort_walk();
`else
    test_rotation(1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised multi-direction traffic-light sequencer that cycles green, yellow and all-red phases round-robin over NUM_DIR approaches. Each phase has a programmable dwell time, and the block adds an optional pedestrian walk phase and a flashing-yellow override. It sits behind the intersection I/O as the single source of lamp drive, and is the generalised successor of the fixed three-state lamp cycler.

## Interface
- NUM_DIR, 2, number of approaches (2..8)
- CNT_W, 16, dwell counter width
- GREEN_CYC, 8, green dwell in clocks (1..2^CNT_W)
- YELLOW_CYC, 3, yellow dwell in clocks (1..2^CNT_W)
- ALLRED_CYC, 2, all-red clearance in clocks (1..2^CNT_W)
- WALK_CYC, 6, pedestrian walk dwell in clocks (1..2^CNT_W)
- FLASH_CYC, 4, flash half-period in clocks (1..2^CNT_W)
- clock  in  1  rising-edge clock; the block uses one clock only
- reset_n  in  1  reset, synchronous and active-low
- enable  in  1  1 = dwell counter runs; 0 = freeze current state and counter
- flash  in  1  level; 1 = flashing-yellow override
- ped_req  in  1  pedestrian request, sampled each clock
- ped_ack  out  1  one-clock pulse on WALK entry
- walk  out  1  1 while in WALK
- light  out  3*NUM_DIR  per approach d, bits [3d+2:3d] = {red, green, yellow}
- active_dir  out  $clog2(NUM_DIR)  approach currently served
- phase  out  3  0 ALL_RED, 1 GREEN, 2 YELLOW, 3 WALK, 4 FLASH

## Operation
- The FSM has five states: ALL_RED, GREEN, YELLOW, WALK, FLASH.
- All outputs are registered and change on the same edge as the state.
- A down-counter loads X_CYC-1 on state entry. The state is left on the clock where the counter is 0 and enable=1. Each state therefore lasts exactly X_CYC enabled clocks.
- Sequence per approach: GREEN(dir) -> YELLOW(dir) -> ALL_RED -> GREEN(next dir).
  - dir advances in ALL_RED exit, with wrap NUM_DIR-1 -> 0.
  - If a pedestrian request is pending at YELLOW exit, the sequence becomes YELLOW -> ALL_RED -> WALK -> ALL_RED -> GREEN(next dir).
- Lamp drive in each state:
  - GREEN: approach dir = 3'b010; all others = 3'b100.
  - YELLOW: approach dir = 3'b001; all others = 3'b100.
  - ALL_RED and WALK: every approach = 3'b100.
  - FLASH: every approach = {0,0,blink}. blink toggles every FLASH_CYC clocks and starts at 1.
- Pedestrian handling:
  - A ped_req high on any clock outside WALK sets a pending flag.
  - ped_req while in WALK is ignored.
  - Pending clears on WALK entry; ped_ack pulses on that same clock.
  - Multiple requests before service produce one WALK.
- Flash handling:
  - flash=1 forces FLASH on the next edge from any state, regardless of enable. A WALK in progress is aborted and the pending flag is cleared.
  - On flash deassertion, FLASH -> ALL_RED with dir = 0 and a full ALLRED_CYC dwell.
- enable=0 freezes the counter, the state and blink. Outputs hold and ped_req is still latched.
- Reset (reset_n=0 at an edge):
  - state ALL_RED, dir 0, counter ALLRED_CYC-1.
  - light all 3'b100, ped_ack 0, walk 0, pending 0, blink 1, phase 0.
  - A reset mid-phase takes effect on that edge, with no completion of the current phase.

## Timing
- Counting from the first edge with reset_n=1 and enable=1, in clocks:
  - cycles 0..ALLRED_CYC-1: ALL_RED.
  - next GREEN_CYC clocks: GREEN(0).
  - next YELLOW_CYC clocks: YELLOW(0).
  - then ALL_RED, then GREEN(1), and so on.
- A full rotation with no requests is NUM_DIR*(GREEN_CYC+YELLOW_CYC+ALLRED_CYC) clocks.
- A serviced pedestrian request adds WALK_CYC+ALLRED_CYC clocks.
- ped_req sampled at the same edge as YELLOW exit counts as pending for that transition.
- FLASH is entered one clock after flash rises, and left one clock after flash falls.
- No green is ever adjacent to another approach's green without YELLOW and ALL_RED between them.

## Configuration
- TLC_PED_EN defined: pending flag, WALK state, ped_ack and walk are implemented as described.
- TLC_PED_EN undefined:
  - WALK logic is not compiled.
  - ped_req is ignored.
  - ped_ack and walk are tied to 0.
  - The sequence never enters WALK; WALK_CYC is unused.

## Test plan
All scenarios use NUM_DIR=2, GREEN=4, YELLOW=2, ALLRED=1, WALK=3, FLASH=2.
- Reset release, enable=1:
  - cycle 0: light=6'b100100.
  - cycles 1-4: 6'b100010.
  - cycles 5-6: 6'b100001.
  - cycle 7: 6'b100100.
  - cycles 8-11: 6'b010100 with active_dir=1.
  - cycle 15: wrap back to dir 0.
- TLC_PED_EN, ped_req pulse at cycle 2:
  - ALL_RED at cycle 7.
  - WALK cycles 8-10, walk=1, ped_ack=1 at cycle 8 only.
  - ALL_RED at cycle 11, GREEN(1) at cycle 12.
  - A second ped_req at cycle 9 produces no extra WALK.
- enable=0 for 5 clocks mid-GREEN: light and phase hold; GREEN still totals 4 enabled clocks.
- flash=1 during GREEN(1):
  - Next clock: phase=4, light=6'b001001.
  - Toggles to 6'b000000 after 2 clocks.
  - flash=0: one clock later ALL_RED, active_dir=0.
- reset_n=0 during YELLOW: next edge shows light=6'b100100, phase=0, ped_ack=0, pending cleared.
- Build without TLC_PED_EN: ped_req pulses have no effect, walk and ped_ack stay 0, and the rotation matches the reset-release scenario.
